// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (LSR bit positions, receiver FSM encoding, frame width).
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_PE   = 2;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with combinational head (zero when empty); a pop frees
// room for a push in the same cycle, a push into a full FIFO without a pop is dropped.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronised serial receiver, 8N1 LSB first, feeding uart_rx_fifo with sticky LSR flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx,
    input  logic                          i_rd,
    input  logic                          i_clr_err,
    output logic [DATA_BITS-1:0]          o_data,
    output logic                          o_data_ready,
    output logic                          o_overrun,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic                 rx_meta, rx_s, rx_prev;
    rx_state_e            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 push, frame_set, overrun_set;
    logic                 fifo_empty, fifo_full;

    // NOTE: sequential state always uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_set;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_n     = bit_idx;
        shreg_n   = shreg;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set = 1'b0;
`endif
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_s) begin
                    state_n = RX_START;
                    bit_n   = '0;
                end
            end
            RX_START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_n   = '0;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_n   = bit_idx + BW'(1);
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_n = RX_PARITY;
`else
                        state_n = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n      = '0;
                    parity_set = (rx_s != even_parity(shreg));
                    state_n    = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n = '0;
                    push  = 1'b1;
                    if (rx_s) begin
                        state_n = RX_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_n   = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = RX_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = RX_IDLE;
            end
        endcase
    end

    // A full FIFO is never empty, so i_rd alone tells whether the pop makes room.
    assign overrun_set = push && fifo_full && !i_rd;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overrun   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_overrun   <= overrun_set | (o_overrun & ~i_clr_err);
            o_frame_err <= frame_set   | (o_frame_err & ~i_clr_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_parity_err <= 1'b0;
        else       o_parity_err <= parity_set | (o_parity_err & ~i_clr_err);
    end
`else
    assign o_parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (i_rd),
        .din   (shreg),
        .dout  (o_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    assign o_data_ready = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench; stimulus drives serial frames and pushes expected bytes,
// a monitor compares every byte the DUT hands over on a read.
module tb_uart_rx_core;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int FB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int FB  = 10;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_rst, i_rx, i_rd, i_clr_err;
    logic [7:0] o_data;
    logic       o_data_ready, o_overrun, o_parity_err, o_frame_err;
    logic [2:0] o_count;

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .i_rd         (i_rd),
        .i_clr_err    (i_clr_err),
        .o_data       (o_data),
        .o_data_ready (o_data_ready),
        .o_overrun    (o_overrun),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0, exp_fe = 1'b0, exp_pe = 1'b0;
    int         rd_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reader policy: 0 never, 1 whenever data is ready, 2 sporadically (lets the FIFO fill).
    task automatic drive_rd();
        case (rd_mode)
            0:       i_rd = 1'b0;
            1:       i_rd = o_data_ready;
            default: i_rd = o_data_ready && ($urandom_range(0, 15) == 0);
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive_rd();
            @(negedge clk);
        end
    endtask

    // Reference model of a completed frame: byte enters the FIFO unless it is full and not read that cycle.
    task automatic model_push(input logic [7:0] b, input logic stop_bit, input logic par_ok);
        if (exp_q.size() >= DEPTH && !i_rd) exp_ovr = 1'b1;
        else                                exp_q.push_back(b);
        if (!stop_bit)       exp_fe = 1'b1;
        if (PAR && !par_ok)  exp_pe = 1'b1;
    endtask

    // Drives one frame; the byte lands on the edge after the last iteration (2 sync + half bit + 9 bits).
    task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_ok,
                        input logic rd_at_push, input int abort_at);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9]  = par_ok ? ^b : ~^b;
        bits[10] = stop_bit;
`else
        bits[9]  = stop_bit;
`endif
        for (int n = 0; n <= FB * CPB; n++) begin
            if (n == abort_at) return;
            i_rx = bits[(n < FB * CPB) ? n / CPB : FB - 1];
            drive_rd();
            if (n == FB * CPB) begin
                if (rd_at_push) i_rd = 1'b1;
                model_push(b, stop_bit, par_ok);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_pop();
        i_rd = 1'b1;
        @(negedge clk);
        i_rd = 1'b0;
    endtask

    task automatic clr_err();
        i_clr_err = 1'b1;
        drive_rd();
        @(negedge clk);
        i_clr_err = 1'b0;
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
        exp_pe  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(o_count),      32'(exp_q.size()));
        check({tag, "_ready"}, 32'(o_data_ready), 32'(exp_q.size() != 0));
        check({tag, "_head"},  32'(o_data),       (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
        check({tag, "_oe"},    32'(o_overrun),    32'(exp_ovr));
        check({tag, "_fe"},    32'(o_frame_err),  32'(exp_fe));
        check({tag, "_pe"},    32'(o_parity_err), 32'(exp_pe));
    endtask

    // Monitor: just before each rising edge, a read of a non-empty FIFO must yield the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!i_rst && i_rd && o_data_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %02h, scoreboard empty", o_data);
                end else begin
                    check("pop_data", 32'(o_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic       stop_bit, par_ok;

        i_rst = 1'b1; i_rx = 1'b1; i_rd = 1'b0; i_clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check_status("reset");
        i_rst = 1'b0;
        idle(4);

        // 1: clean frame, then a read empties the FIFO
        rd_mode = 0;
        send(8'h55, 1'b1, 1'b1, 1'b0, -1);
        check_status("t1");
        do_pop();
        check_status("t1_pop");

        // 2: one-cycle low glitch is rejected at the mid-start sample
        i_rx = 1'b0;
        drive_rd();
        @(negedge clk);
        i_rx = 1'b1;
        idle(10);
        check_status("t2");

        // 3: framing error with a held-low line; next frame only after the line returns high
        send(8'hA3, 1'b0, 1'b1, 1'b0, -1);
        i_rx = 1'b0;
        idle(16);
        check_status("t3_break");
        i_rx = 1'b1;
        idle(3);
        send(8'h01, 1'b1, 1'b1, 1'b0, -1);
        check_status("t3_next");
        clr_err();
        check_status("t3_clr");
        rd_mode = 1;
        idle(6);
        rd_mode = 0;
        check_status("t3_drain");

        // 4: overrun on a full FIFO, then a push coinciding with a read
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1, 1'b1, 1'b0, -1);
        check_status("t4_full");
        send(8'h14, 1'b1, 1'b1, 1'b0, -1);
        check_status("t4_ovr");
        clr_err();
        send(8'h14, 1'b1, 1'b1, 1'b1, -1);
        check_status("t4_rdpush");

        // 5: asynchronous reset in the middle of a frame
        send(8'hFF, 1'b1, 1'b1, 1'b0, 20);
        i_rd  = 1'b0;
        i_rst = 1'b1;
        #1;
        check("t5_rst_count", 32'(o_count),      32'h0);
        check("t5_rst_ready", 32'(o_data_ready), 32'h0);
        check("t5_rst_data",  32'(o_data),       32'h0);
        check("t5_rst_oe",    32'(o_overrun),    32'h0);
        exp_q.delete();
        exp_ovr = 1'b0; exp_fe = 1'b0; exp_pe = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        i_rx  = 1'b1;
        idle(4);
        send(8'h3C, 1'b1, 1'b1, 1'b0, -1);
        check_status("t5_after");
        rd_mode = 1;
        idle(4);
        rd_mode = 0;

`ifdef UART_RX_PARITY_EN
        // 6: parity mismatch is flagged but the byte is kept
        send(8'h07, 1'b1, 1'b0, 1'b0, -1);
        check_status("t6_bad");
        clr_err();
        send(8'h07, 1'b1, 1'b1, 1'b0, -1);
        check_status("t6_good");
        rd_mode = 1;
        idle(6);
        rd_mode = 0;
`endif

        // Randomised traffic with sporadic reads, occasional bad stop bits and flag clears
        rd_mode = 2;
        repeat (30) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 7) != 0);
            par_ok   = ($urandom_range(0, 3) != 0);
            send(b, stop_bit, par_ok, 1'b0, -1);
            i_rx = 1'b1;
            idle($urandom_range(3, 8));
            check_status("rnd");
            if ($urandom_range(0, 5) == 0) clr_err();
        end

        rd_mode = 1;
        idle(12);
        rd_mode = 0;
        idle(1);
        check_status("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
